// File: rtl/banzai_syscfg_slave_if.sv
// ---------------------------------------------------------------------------
// banzai_syscfg_slave_if
// Purpose : AXI4-Lite style bus bundle between a system-config master and
//           the banzai_syscfg_slave power-state register block.
// Signals : aw_* write address channel, w_* write data channel,
//           b_* write response channel, ar_* read address channel,
//           r_* read data channel.
// Modports: master drives requests and response readies,
//           slave drives readies and responses.
// ---------------------------------------------------------------------------
interface banzai_syscfg_slave_if;
  logic [31:0] aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/banzai_syscfg_slave.sv
// ---------------------------------------------------------------------------
// banzai_syscfg_slave
// Purpose : Bank of NUM_COMP power-state registers (STATE_W bits each),
//           one word per component starting at BASE_ADDR, reachable over an
//           AXI4-Lite style slave port.
// Ports   : clk        - single clock, rising edge
//           rst_n      - asynchronous active-low reset
//           bus        - slave modport of banzai_syscfg_slave_if (AW/W/B/AR/R)
//           pwr_state  - all registers concatenated, register i at
//                        [i*STATE_W +: STATE_W]
//           pwr_change - one-cycle per-component pulse on each effective
//                        write (only when BANZAI_SYSCFG_CHANGE_EN is defined)
// Options : define BANZAI_SYSCFG_CHANGE_EN to add the pwr_change port/logic.
// ---------------------------------------------------------------------------
module banzai_syscfg_slave #(
  parameter int          NUM_COMP  = 8,
  parameter int          STATE_W   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  banzai_syscfg_slave_if.slave          bus,
  output logic [NUM_COMP*STATE_W-1:0]   pwr_state
`ifdef BANZAI_SYSCFG_CHANGE_EN
  ,
  output logic [NUM_COMP-1:0]           pwr_change
`endif
);

  localparam logic [31:0] SPAN        = 32'(4 * NUM_COMP);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [STATE_W-1:0] r_regs [NUM_COMP];

  logic        r_awHeld;
  logic [31:0] r_awAddr;
  logic        r_wHeld;
  logic [31:0] r_wData;
  logic [3:0]  r_wStrb;
  logic        r_bValid;
  logic [1:0]  r_bResp;

  logic        r_rValid;
  logic [31:0] r_rData;
  logic [1:0]  r_rResp;

  logic               w_awReady;
  logic               w_wReady;
  logic               w_awHs;
  logic               w_wHs;
  logic               w_commit;
  logic [31:0]        w_wrOffset;
  logic               w_wrInRange;
  logic [29:0]        w_wrIdx;
  logic [STATE_W-1:0] w_wrOld;
  logic [31:0]        w_strbMask32;
  logic [STATE_W-1:0] w_strbMask;
  logic [STATE_W-1:0] w_wrMerged;

  logic               w_arReady;
  logic               w_arHs;
  logic [31:0]        w_rdOffset;
  logic               w_rdInRange;
  logic [29:0]        w_rdIdx;
  logic [STATE_W-1:0] w_rdVal;

  // Byte-lane bits and sub-word address bits carry no meaning for the
  // register contents; they are gathered here so the intent is explicit.
  logic w_unused;
  assign w_unused = ^{r_wData, w_strbMask32, w_wrOffset[1:0], w_rdOffset[1:0]};

  // ------------------------------------------------------------------
  // Write channel: AW and W are captured independently and both stall
  // while a response is outstanding, so at most one write is in flight.
  // ------------------------------------------------------------------
  assign w_awReady = !r_awHeld && !r_bValid;
  assign w_wReady  = !r_wHeld  && !r_bValid;
  assign w_awHs    = bus.aw_valid && w_awReady;
  assign w_wHs     = bus.w_valid  && w_wReady;
  assign w_commit  = r_awHeld && r_wHeld;

  // The subtraction wraps for addresses below the base, so the explicit
  // lower-bound test is what rejects them.
  assign w_wrOffset  = r_awAddr - BASE_ADDR;
  assign w_wrInRange = (r_awAddr >= BASE_ADDR) && (w_wrOffset < SPAN);
  assign w_wrIdx     = w_wrOffset[31:2];

  always_comb begin
    w_wrOld = '0;
    for (int i = 0; i < NUM_COMP; i++) begin
      if (w_wrIdx == 30'(i)) w_wrOld = r_regs[i];
    end
  end

  // Expand the four lane strobes to a per-bit mask, then keep only the
  // stored width so upper data bits are dropped.
  assign w_strbMask32 = {{8{r_wStrb[3]}}, {8{r_wStrb[2]}},
                         {8{r_wStrb[1]}}, {8{r_wStrb[0]}}};
  assign w_strbMask   = w_strbMask32[STATE_W-1:0];
  assign w_wrMerged   = (w_wrOld & ~w_strbMask) | (r_wData[STATE_W-1:0] & w_strbMask);

  // Holds are cleared by the commit itself; reset drops any half-built
  // write so no response can appear later for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awHeld <= 1'b0;
      r_awAddr <= '0;
      r_wHeld  <= 1'b0;
      r_wData  <= '0;
      r_wStrb  <= '0;
    end else if (w_commit) begin
      r_awHeld <= 1'b0;
      r_wHeld  <= 1'b0;
    end else begin
      if (w_awHs) begin
        r_awHeld <= 1'b1;
        r_awAddr <= bus.aw_addr;
      end
      if (w_wHs) begin
        r_wHeld <= 1'b1;
        r_wData <= bus.w_data;
        r_wStrb <= bus.w_strb;
      end
    end
  end

  // Response is raised on the commit edge and held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bValid <= 1'b0;
      r_bResp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bValid <= 1'b1;
      r_bResp  <= w_wrInRange ? RESP_OKAY : RESP_SLVERR;
    end else if (r_bValid && bus.b_ready) begin
      r_bValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COMP; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_COMP; i++) begin
        if (w_commit && w_wrInRange && (w_wrIdx == 30'(i))) r_regs[i] <= w_wrMerged;
      end
    end
  end

`ifdef BANZAI_SYSCFG_CHANGE_EN
  logic [NUM_COMP-1:0] r_pwrChange;

  // Pulse lines up with the b_valid-assert cycle; an all-zero strobe
  // changes nothing and so does not pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwrChange <= '0;
    end else begin
      for (int i = 0; i < NUM_COMP; i++) begin
        r_pwrChange[i] <= w_commit && w_wrInRange && (r_wStrb != 4'b0000) &&
                          (w_wrIdx == 30'(i));
      end
    end
  end

  assign pwr_change = r_pwrChange;
`endif

  // ------------------------------------------------------------------
  // Read channel: one outstanding read; data sampled from the register
  // array before any same-edge write lands (non-blocking semantics).
  // ------------------------------------------------------------------
  assign w_arReady   = !r_rValid;
  assign w_arHs      = bus.ar_valid && w_arReady;
  assign w_rdOffset  = bus.ar_addr - BASE_ADDR;
  assign w_rdInRange = (bus.ar_addr >= BASE_ADDR) && (w_rdOffset < SPAN);
  assign w_rdIdx     = w_rdOffset[31:2];

  always_comb begin
    w_rdVal = '0;
    for (int i = 0; i < NUM_COMP; i++) begin
      if (w_rdIdx == 30'(i)) w_rdVal = r_regs[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rValid <= 1'b0;
      r_rData  <= '0;
      r_rResp  <= RESP_OKAY;
    end else if (w_arHs) begin
      r_rValid <= 1'b1;
      r_rData  <= w_rdInRange ? 32'(w_rdVal) : 32'h0;
      r_rResp  <= w_rdInRange ? RESP_OKAY : RESP_SLVERR;
    end else if (r_rValid && bus.r_ready) begin
      r_rValid <= 1'b0;
    end
  end

  always_comb begin
    pwr_state = '0;
    for (int i = 0; i < NUM_COMP; i++) pwr_state[i*STATE_W +: STATE_W] = r_regs[i];
  end

  assign bus.aw_ready = w_awReady;
  assign bus.w_ready  = w_wReady;
  assign bus.b_valid  = r_bValid;
  assign bus.b_resp   = r_bResp;
  assign bus.ar_ready = w_arReady;
  assign bus.r_valid  = r_rValid;
  assign bus.r_data   = r_rData;
  assign bus.r_resp   = r_rResp;

endmodule

// File: tb/tb_banzai_syscfg_slave.sv
// ---------------------------------------------------------------------------
// tb_banzai_syscfg_slave
// Purpose : Self-checking bench for banzai_syscfg_slave. A transaction-level
//           model (register array + pending AW/W + expected read queue)
//           tracks what the bus must return; a negedge process compares the
//           DUT to it every cycle, and directed sequences add literal checks
//           on timing and boundary cases.
// Options : compile with BANZAI_SYSCFG_CHANGE_EN to also exercise pwr_change.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_banzai_syscfg_slave;

  localparam int          NC   = 8;
  localparam int          SW   = 4;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  banzai_syscfg_slave_if bus ();
  logic [NC*SW-1:0] pwr_state;
`ifdef BANZAI_SYSCFG_CHANGE_EN
  logic [NC-1:0] pwr_change;
`endif

  banzai_syscfg_slave #(
    .NUM_COMP  (NC),
    .STATE_W   (SW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .pwr_state (pwr_state)
`ifdef BANZAI_SYSCFG_CHANGE_EN
    ,
    .pwr_change(pwr_change)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rdExp_t;

  logic [SW-1:0] model [NC];
  rdExp_t        rdQ [$];
  logic          pendAw, pendW;
  logic [31:0]   pendAwAddr, pendWData;
  logic [3:0]    pendWStrb;
  logic [1:0]    curBResp;
  rdExp_t        curRd;
  logic          prevAwHs, prevWHs, prevArHs, prevBValid, prevRValid;
  logic [31:0]   prevAwAddr, prevWData, prevArAddr;
  logic [3:0]    prevWStrb;
  logic [NC-1:0] expChange;

  function automatic bit inRange(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(4 * NC));
  endfunction

  function automatic int wordIndex(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic rdExp_t modelRead(input logic [31:0] a);
    rdExp_t e;
    e.data = 32'h0;
    e.resp = 2'b10;
    if (inRange(a)) begin
      e.resp = 2'b00;
      for (int i = 0; i < NC; i++) if (i == wordIndex(a)) e.data = 32'(model[i]);
    end
    return e;
  endfunction

  function automatic logic [NC*SW-1:0] modelState();
    logic [NC*SW-1:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v[i*SW +: SW] = model[i];
    return v;
  endfunction

  // Apply the pending write to the model as a whole word with byte-lane
  // merge, then keep only the stored width.
  task automatic modelCommit();
    logic [31:0] cur;
    expChange = '0;
    if (inRange(pendAwAddr)) begin
      curBResp = 2'b00;
      for (int i = 0; i < NC; i++) begin
        if (i == wordIndex(pendAwAddr)) begin
          cur = 32'(model[i]);
          if (pendWStrb[0]) cur[7:0]   = pendWData[7:0];
          if (pendWStrb[1]) cur[15:8]  = pendWData[15:8];
          if (pendWStrb[2]) cur[23:16] = pendWData[23:16];
          if (pendWStrb[3]) cur[31:24] = pendWData[31:24];
          model[i] = cur[SW-1:0];
          if (pendWStrb != 4'b0000) expChange[i] = 1'b1;
        end
      end
    end else begin
      curBResp = 2'b10;
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_aw_ready", 64'(bus.aw_ready), 64'd1);
      checkOutput("rst_w_ready",  64'(bus.w_ready),  64'd1);
      checkOutput("rst_ar_ready", 64'(bus.ar_ready), 64'd1);
      checkOutput("rst_b_valid",  64'(bus.b_valid),  64'd0);
      checkOutput("rst_r_valid",  64'(bus.r_valid),  64'd0);
      checkOutput("rst_b_resp",   64'(bus.b_resp),   64'd0);
      checkOutput("rst_r_resp",   64'(bus.r_resp),   64'd0);
      checkOutput("rst_r_data",   64'(bus.r_data),   64'd0);
      checkOutput("rst_pwr_state", 64'(pwr_state),   64'd0);
`ifdef BANZAI_SYSCFG_CHANGE_EN
      checkOutput("rst_pwr_change", 64'(pwr_change), 64'd0);
`endif
      for (int i = 0; i < NC; i++) model[i] = '0;
      rdQ.delete();
      pendAw = 1'b0; pendW = 1'b0;
      prevAwHs = 1'b0; prevWHs = 1'b0; prevArHs = 1'b0;
      prevBValid = 1'b0; prevRValid = 1'b0;
      expChange = '0;
    end else begin
      expChange = '0;
      if (prevAwHs) begin pendAw = 1'b1; pendAwAddr = prevAwAddr; end
      if (prevWHs)  begin pendW = 1'b1; pendWData = prevWData; pendWStrb = prevWStrb; end
      if (prevArHs) rdQ.push_back(modelRead(prevArAddr));

      if (bus.b_valid && !prevBValid) begin
        checkOutput("b_has_txn", 64'(pendAw && pendW), 64'd1);
        if (pendAw && pendW) modelCommit();
        pendAw = 1'b0;
        pendW  = 1'b0;
      end
      checkOutput("pwr_state", 64'(pwr_state), 64'(modelState()));
`ifdef BANZAI_SYSCFG_CHANGE_EN
      checkOutput("pwr_change", 64'(pwr_change), 64'(expChange));
`endif
      if (bus.b_valid) checkOutput("b_resp", 64'(bus.b_resp), 64'(curBResp));

      if (bus.r_valid && !prevRValid) begin
        checkOutput("r_has_req", 64'(rdQ.size() != 0), 64'd1);
        if (rdQ.size() != 0) curRd = rdQ.pop_front();
      end
      if (bus.r_valid) begin
        checkOutput("r_data", 64'(bus.r_data), 64'(curRd.data));
        checkOutput("r_resp", 64'(bus.r_resp), 64'(curRd.resp));
      end

      prevAwHs   = bus.aw_valid && bus.aw_ready;
      prevAwAddr = bus.aw_addr;
      prevWHs    = bus.w_valid && bus.w_ready;
      prevWData  = bus.w_data;
      prevWStrb  = bus.w_strb;
      prevArHs   = bus.ar_valid && bus.ar_ready;
      prevArAddr = bus.ar_addr;
      prevBValid = bus.b_valid;
      prevRValid = bus.r_valid;
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeTxn(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] expResp);
    bit awDone, wDone, awHs, wHs;
    awDone = 0; wDone = 0;
    bus.aw_addr = addr; bus.aw_valid = 1'b1;
    bus.w_data = data; bus.w_strb = strb; bus.w_valid = 1'b1;
    for (int c = 0; c < 20 && !(awDone && wDone); c++) begin
      awHs = bus.aw_valid && bus.aw_ready;
      wHs  = bus.w_valid && bus.w_ready;
      tick();
      if (awHs) begin awDone = 1; bus.aw_valid = 1'b0; end
      if (wHs)  begin wDone = 1;  bus.w_valid = 1'b0; end
    end
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    checkOutput("wr_accepted", 64'(awDone && wDone), 64'd1);
    for (int c = 0; c < 20 && !bus.b_valid; c++) tick();
    checkOutput("wr_b_valid", 64'(bus.b_valid), 64'd1);
    checkOutput("wr_b_resp", 64'(bus.b_resp), 64'(expResp));
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    checkOutput("wr_b_done", 64'(bus.b_valid), 64'd0);
  endtask

  task automatic readTxn(input logic [31:0] addr, input logic [31:0] expData,
                         input logic [1:0] expResp);
    bus.ar_addr = addr; bus.ar_valid = 1'b1;
    for (int c = 0; c < 20 && !bus.ar_ready; c++) tick();
    checkOutput("rd_ar_ready", 64'(bus.ar_ready), 64'd1);
    tick();
    bus.ar_valid = 1'b0;
    checkOutput("rd_r_valid", 64'(bus.r_valid), 64'd1);
    checkOutput("rd_r_data", 64'(bus.r_data), 64'(expData));
    checkOutput("rd_r_resp", 64'(bus.r_resp), 64'(expResp));
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    checkOutput("rd_r_done", 64'(bus.r_valid), 64'd0);
  endtask

  // ------------------------------------------------------------------
  // Directed sequence
  // ------------------------------------------------------------------
  task automatic applyStimulus();
    // Reset values
    repeat (3) tick();
    checkOutput("reset_aw_ready", 64'(bus.aw_ready), 64'd1);
    checkOutput("reset_pwr_state", 64'(pwr_state), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic write/read of register 1
    writeTxn(32'h0001_0004, 32'h5, 4'hF, 2'b00);
    checkOutput("reg1_after_write", 64'(pwr_state[7:4]), 64'h5);
    readTxn(32'h0001_0004, 32'h5, 2'b00);

    // Write latency: AW+W at edge N, response after N+1
    bus.aw_addr = 32'h0001_0000; bus.aw_valid = 1'b1;
    bus.w_data = 32'h3; bus.w_strb = 4'h1; bus.w_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    checkOutput("lat_b_valid_n", 64'(bus.b_valid), 64'd0);
    checkOutput("lat_aw_ready_n", 64'(bus.aw_ready), 64'd0);
    checkOutput("lat_w_ready_n", 64'(bus.w_ready), 64'd0);
    checkOutput("lat_reg0_n", 64'(pwr_state[3:0]), 64'h0);
    tick();
    checkOutput("lat_b_valid_n1", 64'(bus.b_valid), 64'd1);
    checkOutput("lat_reg0_n1", 64'(pwr_state[3:0]), 64'h3);
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    checkOutput("lat_aw_ready_after", 64'(bus.aw_ready), 64'd1);

    // Out-of-range accesses
    writeTxn(32'h0001_0020, 32'hF, 4'hF, 2'b10);
    checkOutput("oor_write_no_change", 64'(pwr_state), 64'h0000_0053);
    readTxn(32'h0001_0020, 32'h0, 2'b10);
    readTxn(32'h0000_FFFC, 32'h0, 2'b10);

    // Last register, upper data bits dropped, low address bits ignored
    writeTxn(32'h0001_001C, 32'hFFFF_FFF9, 4'h1, 2'b00);
    checkOutput("reg7_truncated", 64'(pwr_state[31:28]), 64'h9);
    readTxn(32'h0001_001F, 32'h9, 2'b00);

    // Lane 0 strobe clear: register unchanged but OKAY
    writeTxn(32'h0001_0004, 32'hA, 4'hE, 2'b00);
    checkOutput("strb_masked", 64'(pwr_state[7:4]), 64'h5);

    // W arrives 3 cycles before AW
    bus.w_data = 32'h7; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    tick();
    bus.w_valid = 1'b0;
    checkOutput("early_w_ready_low", 64'(bus.w_ready), 64'd0);
    checkOutput("early_aw_ready_high", 64'(bus.aw_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("early_no_b", 64'(bus.b_valid), 64'd0);
    end
    bus.aw_addr = 32'h0001_0018; bus.aw_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0;
    checkOutput("early_b_at_n", 64'(bus.b_valid), 64'd0);
    tick();
    checkOutput("early_b_at_n1", 64'(bus.b_valid), 64'd1);
    checkOutput("early_reg6", 64'(pwr_state[27:24]), 64'h7);
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput("early_single_b", 64'(bus.b_valid), 64'd0);
    end

    // Back-pressure on B for 5 cycles
    bus.aw_addr = 32'h0002_0000; bus.aw_valid = 1'b1;
    bus.w_data = 32'h1; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_b_valid", 64'(bus.b_valid), 64'd1);
      checkOutput("bp_b_resp", 64'(bus.b_resp), 64'h2);
      checkOutput("bp_aw_ready", 64'(bus.aw_ready), 64'd0);
      checkOutput("bp_w_ready", 64'(bus.w_ready), 64'd0);
      tick();
    end
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    writeTxn(32'h0001_0008, 32'h2, 4'hF, 2'b00);
    checkOutput("bp_next_write", 64'(pwr_state[11:8]), 64'h2);

    // Read sampling register 3 on the same edge its write commits
    bus.aw_addr = 32'h0001_000C; bus.aw_valid = 1'b1;
    bus.w_data = 32'h6; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    bus.ar_addr = 32'h0001_000C; bus.ar_valid = 1'b1;
    tick();
    bus.ar_valid = 1'b0;
    checkOutput("same_edge_r_valid", 64'(bus.r_valid), 64'd1);
    checkOutput("same_edge_old_data", 64'(bus.r_data), 64'h0);
    checkOutput("same_edge_b_valid", 64'(bus.b_valid), 64'd1);
    checkOutput("same_edge_new_reg", 64'(pwr_state[15:12]), 64'h6);
    bus.b_ready = 1'b1; bus.r_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0; bus.r_ready = 1'b0;
    readTxn(32'h0001_000C, 32'h6, 2'b00);

`ifdef BANZAI_SYSCFG_CHANGE_EN
    // Change pulse on register 2, none for an all-zero strobe
    bus.aw_addr = 32'h0001_0008; bus.aw_valid = 1'b1;
    bus.w_data = 32'hA; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    checkOutput("chg_before", 64'(pwr_change), 64'h00);
    tick();
    checkOutput("chg_pulse", 64'(pwr_change), 64'h04);
    tick();
    checkOutput("chg_one_cycle", 64'(pwr_change), 64'h00);
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    writeTxn(32'h0001_0008, 32'h3, 4'h0, 2'b00);
    checkOutput("chg_zero_strb_reg", 64'(pwr_state[11:8]), 64'hA);
`endif

    // Reset in the middle of a write with only AW captured
    bus.aw_addr = 32'h0001_0014; bus.aw_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0;
    checkOutput("mid_aw_held", 64'(bus.aw_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_aw_ready", 64'(bus.aw_ready), 64'd1);
    checkOutput("mid_rst_w_ready", 64'(bus.w_ready), 64'd1);
    checkOutput("mid_rst_b_valid", 64'(bus.b_valid), 64'd0);
    checkOutput("mid_rst_pwr_state", 64'(pwr_state), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.w_data = 32'h4; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    tick();
    bus.w_valid = 1'b0;
    checkOutput("mid_w_captured", 64'(bus.w_ready), 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("mid_no_b", 64'(bus.b_valid), 64'd0);
    end
    checkOutput("mid_regs_clear", 64'(pwr_state), 64'd0);
    bus.aw_addr = 32'h0001_0014; bus.aw_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0;
    tick();
    checkOutput("mid_late_b", 64'(bus.b_valid), 64'd1);
    checkOutput("mid_late_reg5", 64'(pwr_state[23:20]), 64'h4);
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    bus.aw_addr = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_valid = 1'b0;
    bus.b_ready = 1'b0;
    bus.ar_addr = '0; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b0;
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/banzai_syscfg_slave.md
BANZAI_SYSCFG_SLAVE -- requirements
Module: banzai_syscfg_slave

Interface
REQ-001 SHALL have parameter NUM_COMP, default 8, the number of power-state registers, one per component.
REQ-002 SHALL have parameter STATE_W, default 4, the stored width of each power-state register.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0001_0000, the byte address of register 0.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port aw_addr  input  32  write address.
REQ-007 SHALL have port aw_valid  input  1  write address valid.
REQ-008 SHALL have port aw_ready  output  1  write address ready.
REQ-009 SHALL have port w_data  input  32  write data.
REQ-010 SHALL have port w_strb  input  4  write byte strobes.
REQ-011 SHALL have port w_valid  input  1  write data valid.
REQ-012 SHALL have port w_ready  output  1  write data ready.
REQ-013 SHALL have port b_resp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-014 SHALL have port b_valid  output  1  write response valid.
REQ-015 SHALL have port b_ready  input  1  write response ready.
REQ-016 SHALL have port ar_addr  input  32  read address.
REQ-017 SHALL have port ar_valid  input  1  read address valid.
REQ-018 SHALL have port ar_ready  output  1  read address ready.
REQ-019 SHALL have port r_data  output  32  read data, zero-extended register value.
REQ-020 SHALL have port r_resp  output  2  read response, same encoding as b_resp.
REQ-021 SHALL have port r_valid  output  1  read data valid.
REQ-022 SHALL have port r_ready  input  1  read data ready.
REQ-023 SHALL have port pwr_state  output  NUM_COMP*STATE_W  concatenated registers; register i at bits [i*STATE_W +: STATE_W].
REQ-024 SHALL have port pwr_change  output  NUM_COMP  one-cycle per-component write pulse; present only with BANZAI_SYSCFG_CHANGE_EN.

Function
REQ-025 SHALL decode offset = addr - BASE_ADDR, index = offset>>2 with addr[1:0] ignored; it is in range iff addr >= BASE_ADDR and offset < 4*NUM_COMP.
REQ-026 SHALL capture AW and W independently: aw_ready = !aw_held && !b_valid; w_ready = !w_held && !b_valid.
REQ-027 SHALL, on the edge after both AW and W are held (same-edge arrival allowed), commit the write, clear both holds and assert b_valid; AW+W at edge N gives b_valid and updated register after edge N+1.
REQ-028 SHALL update only bits of register[index] whose byte lane strobe is set, storing bits [STATE_W-1:0] and discarding upper data bits.
REQ-029 SHALL give an in-range write OKAY (including w_strb=0, which leaves the register unchanged); an out-of-range write SHALL return SLVERR and modify nothing.
REQ-030 SHALL hold b_valid and b_resp stable until b_valid && b_ready, then deassert b_valid on that edge.
REQ-031 SHALL drive ar_ready = !r_valid; an AR handshake at edge N SHALL register r_data/r_resp and assert r_valid after edge N.
REQ-032 SHALL return register value with OKAY for in-range reads; an out-of-range read SHALL return r_data=0 with SLVERR.
REQ-033 SHALL hold r_valid, r_data and r_resp stable until r_ready; the read and write channels are fully independent.
REQ-034 SHALL return the pre-commit value when a read samples a register on the same edge that a write commits to it.

Reset
REQ-035 SHALL, while rst_n=0, clear all registers, holds and pwr_change, and drive b_valid=0, r_valid=0, b_resp=0, r_resp=0, r_data=0, aw_ready=1, w_ready=1, ar_ready=1.
REQ-036 SHALL discard any partially captured write on reset assertion mid-transaction; no response is issued afterwards.

Configuration
REQ-037 SHALL, with BANZAI_SYSCFG_CHANGE_EN defined, pulse pwr_change[index] high for exactly the b_valid-assert cycle of each OKAY write with a non-zero strobe.
REQ-038 SHALL, without BANZAI_SYSCFG_CHANGE_EN, omit the pwr_change port and its logic; all other behaviour is unchanged.

Verification
REQ-039 SHALL test: write 0x0001_0004 data 0x5 strb 0xF -> b_resp OKAY, pwr_state[7:4]=4'h5; read 0x0001_0004 -> r_data 0x5, OKAY.
REQ-040 SHALL test: write 0x0001_0020 (NUM_COMP=8) -> SLVERR, pwr_state unchanged; read 0x0001_0020 -> r_data 0, SLVERR.
REQ-041 SHALL test: W valid 3 cycles before AW -> w_ready low after W capture, single b_valid one cycle after AW handshake.
REQ-042 SHALL test: b_ready low 5 cycles -> b_valid/b_resp stable, aw_ready and w_ready held low, next write accepted after B handshake.
REQ-043 SHALL test: AW captured, rst_n pulsed low before W -> all outputs at reset values, no b_valid when W later arrives alone.
REQ-044 SHALL test (macro defined): write 0xA to register 2 -> pwr_change=8'b0000_0100 for one cycle; with w_strb=0 -> no pulse, OKAY.
